poly_ddfs: RTL and testbench
============================

POLY_DDFS -- requirements
Module: poly_ddfs

Interface
REQ-001 Parameter NV, default 4: number of voices (1..16).
REQ-002 Parameter PW, default 30: phase accumulator width per voice.
REQ-003 Parameter FILE_NAME, default "": sine table init file passed to the ROM.
REQ-004 clk  in  1: single clock; all state on rising edge.
REQ-005 reset_n  in  1: asynchronous, active-low reset.
REQ-006 wr_en  in  1: register write strobe, one write per cycle.
REQ-007 wr_voice  in  $clog2(NV): target voice of write.
REQ-008 wr_sel  in  2: 0=fcw, 1=pha, 2=env, 3=wave (wave only under WAVE_SEL_EN; else ignored).
REQ-009 wr_data  in  PW: write data; env uses [15:0], wave uses [1:0].
REQ-010 tick  in  1: one-cycle sample strobe starting a mix sweep.
REQ-011 pcm_out  out  16: signed mixed sample, held between sweeps.
REQ-012 pcm_valid  out  1: one-cycle pulse when pcm_out updates.
REQ-013 busy  out  1: high while a sweep is in progress.
REQ-014 overrun  out  1: sticky; set when tick arrives while busy.

Function
REQ-015 Per-voice registers fcw, pha (PW bits), env (signed Q2.14), wave (2 bits) SHALL be written the cycle after wr_en; writes are accepted in every state.
REQ-016 FSM states IDLE, SWEEP, DRAIN; IDLE->SWEEP on tick; SWEEP lasts NV cycles (one voice issued per cycle, index 0..NV-1); DRAIN lasts 3 cycles; then IDLE.
REQ-017 In SWEEP, ROM address for voice k SHALL be (p[k]+pha[k])[PW-1:PW-8]; ROM read latency 1 cycle.
REQ-018 Product env*amp (signed 16x16=32) SHALL be registered; term = product[29:14].
REQ-019 Terms SHALL accumulate in a signed accumulator of 16+$clog2(NV)+1 bits, cleared when tick is accepted.
REQ-020 At end of DRAIN the accumulator SHALL be saturated to [-32768, 32767], loaded into pcm_out, pcm_valid pulsed; tick-to-pcm_valid latency exactly NV+4 cycles.
REQ-021 Phase p[k] SHALL advance by fcw[k] in the cycle voice k is issued, wrapping modulo 2^PW.
REQ-022 A write to fcw/pha/env of voice k during a sweep SHALL take effect from the next sweep if voice k has already been issued, else in the current sweep.
REQ-023 tick while busy SHALL be ignored and set overrun; overrun clears only on reset.
REQ-024 busy SHALL be high from the cycle after an accepted tick until the cycle pcm_valid pulses, inclusive.

Reset
REQ-025 On reset_n low: FSM IDLE, all fcw/pha/env/wave/phase registers, accumulator, pcm_out, pcm_valid, busy, overrun SHALL be 0, immediately and asynchronously.
REQ-026 Reset mid-sweep SHALL abort it with no pcm_valid pulse.

Configuration
REQ-027 Macro POLY_DDFS_WAVE_SEL_EN defined: wave 0=sine ROM, 1=square (+/-0x7FFF from phase MSB), 2=sawtooth (phase[PW-1:PW-16] as signed), 3=silence (0).
REQ-028 Macro undefined: wave registers absent, all voices sine; wr_sel=3 writes ignored.

Structure
REQ-029 Package poly_ddfs_pkg SHALL hold the FSM state enum, wr_sel codes, wave codes, and saturation limits.
REQ-030 The sine table SHALL be the existing music_rom sub-module, one instance shared by all voices.

Verification
REQ-031 NV=4, all env=0, tick -> pcm_valid exactly 8 cycles later, pcm_out=0, busy high 8 cycles.
REQ-032 Voice 0 fcw=2^22, env=0x4000, others env=0; 256 ticks -> pcm_out traces one full sine period matching ROM contents.
REQ-033 All 4 voices env=0x4000, pha set so ROM amp=0x7FFF each -> pcm_out saturates to 32767, likewise -32768 for 0x8001.
REQ-034 Second tick 2 cycles after first -> ignored, overrun=1, exactly one pcm_valid.
REQ-035 reset_n low 3 cycles into sweep -> no pcm_valid, all outputs 0; next tick gives normal result.
REQ-036 With POLY_DDFS_WAVE_SEL_EN, voice 0 wave=1, env=0x4000, phase MSB=1 -> pcm_out=-32767; wave=3 -> 0.

Source files
------------

// File: rtl/poly_ddfs_pkg.sv
// poly_ddfs_pkg -- shared definitions for the polyphonic DDS mixer.
//   state_t        : sweep controller states
//   SEL_*          : wr_sel register-select codes
//   WAVE_*         : per-voice waveform codes (used when POLY_DDFS_WAVE_SEL_EN is defined)
//   SAT_MAX/MIN    : 16-bit output saturation limits
//   q14_term       : Q2.14 product to 16-bit mix term
//   sine_amp       : sine table contents used by music_rom
package poly_ddfs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [1:0] SEL_FCW  = 2'd0;
   localparam logic [1:0] SEL_PHA  = 2'd1;
   localparam logic [1:0] SEL_ENV  = 2'd2;
   localparam logic [1:0] SEL_WAVE = 2'd3;

   localparam logic [1:0] WAVE_SINE   = 2'd0;
   localparam logic [1:0] WAVE_SQUARE = 2'd1;
   localparam logic [1:0] WAVE_SAW    = 2'd2;
   localparam logic [1:0] WAVE_SILENT = 2'd3;

   localparam logic signed [15:0] SAT_MAX    = 16'sh7FFF;
   localparam logic signed [15:0] SAT_MIN    = 16'sh8000;
   localparam logic signed [15:0] SQUARE_POS = 16'sh7FFF;
   localparam logic signed [15:0] SQUARE_NEG = 16'sh8001;

   // Index of the final DRAIN cycle (DRAIN lasts three cycles).
   localparam logic [1:0] DRAIN_LAST = 2'd2;

   // env is Q2.14, so dropping 14 fraction bits rescales the product to the amp range.
   function automatic logic signed [15:0] q14_term(input logic signed [31:0] product);
      return product[29:14];
   endfunction

   // One period over 256 entries: each half-period is a parabola x*(128-x) scaled so
   // the peak at x=64 is exactly +/-32767; the second half is the negated first half.
   function automatic logic signed [15:0] sine_amp(input logic [7:0] addr);
      logic [6:0]  x;
      logic [13:0] bump;
      logic [28:0] scaled;
      logic [15:0] mag;
      x      = addr[6:0];
      bump   = 14'(x) * (14'd128 - 14'(x));
      scaled = 29'(bump) * 29'd32767;
      mag    = 16'(scaled >> 12);
      return addr[7] ? -$signed(mag) : $signed(mag);
   endfunction

endpackage

// File: rtl/music_rom.sv
// music_rom -- 256 x 16 signed sine table with a registered read (latency 1).
//   clk  : read clock
//   addr : table index, one full period over 0..255
//   data : signed amplitude, valid the cycle after addr
// The table is generated from sine_amp in poly_ddfs_pkg. FILE_NAME identifies an
// external table image for flows that preload ROM contents.
module music_rom
   import poly_ddfs_pkg::*;
#(
   parameter FILE_NAME = ""
)
(
   input  logic        clk,
   input  logic [7:0]  addr,
   output logic [15:0] data
);

   // Registered table read.
   always_ff @(posedge clk) begin
      data <= sine_amp(addr);
   end

endmodule

// File: rtl/poly_ddfs.sv
// poly_ddfs -- time-multiplexed polyphonic DDS voice mixer.
// Each tick sweeps the NV voices through one shared sine ROM, scales each voice by its
// Q2.14 envelope, sums the terms and publishes a saturated 16-bit sample NV+4 cycles
// after the tick.
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   wr_en/wr_voice/wr_sel/wr_data : per-voice register write (fcw, pha, env, wave)
//   tick                     : starts a mix sweep
//   pcm_out / pcm_valid      : mixed sample and its one-cycle update strobe
//   busy                     : sweep in progress, through the pcm_valid cycle
//   overrun                  : sticky, tick arrived while busy
// Option: define POLY_DDFS_WAVE_SEL_EN to add per-voice waveform selection
// (sine / square / sawtooth / silence); without it every voice is sine.
module poly_ddfs
   import poly_ddfs_pkg::*;
#(
   parameter int NV        = 4,
   parameter int PW        = 30,
   parameter     FILE_NAME = ""
)
(
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 wr_en,
   input  logic [((NV > 1) ? $clog2(NV) : 1)-1:0] wr_voice,
   input  logic [1:0]                           wr_sel,
   input  logic [PW-1:0]                        wr_data,
   input  logic                                 tick,
   output logic [15:0]                          pcm_out,
   output logic                                 pcm_valid,
   output logic                                 busy,
   output logic                                 overrun
);

   localparam int VW = (NV > 1) ? $clog2(NV) : 1;
   localparam int AW = 16 + $clog2(NV) + 1;
   localparam logic [VW-1:0] LAST_VOICE = VW'(NV - 1);
   localparam logic signed [AW-1:0] ACC_MAX = {{(AW-16){SAT_MAX[15]}}, SAT_MAX};
   localparam logic signed [AW-1:0] ACC_MIN = {{(AW-16){SAT_MIN[15]}}, SAT_MIN};

   // Per-voice control and phase state
   logic [PW-1:0]        fcw_r   [NV];
   logic [PW-1:0]        pha_r   [NV];
   logic [PW-1:0]        phase_r [NV];
   logic signed [15:0]   env_r   [NV];

   // Sweep controller
   state_t               state_r;
   state_t               next_state_s;
   logic [VW-1:0]        voice_r;
   logic [1:0]           drain_r;
   logic                 accept_s;
   logic                 issue_s;
   logic                 finish_s;

   // Datapath
   logic [PW-1:0]        sum_s;
   logic [7:0]           rom_addr_s;
   logic signed [15:0]   rom_data_s;
   logic signed [15:0]   amp_s;
   logic                 issue_d1_r;
   logic                 issue_d2_r;
   logic signed [15:0]   env_d1_r;
   logic signed [31:0]   env_ext_s;
   logic signed [31:0]   amp_ext_s;
   logic signed [31:0]   product_r;
   logic signed [15:0]   term_s;
   logic signed [AW-1:0] acc_r;
   logic signed [15:0]   sat_s;

`ifdef POLY_DDFS_WAVE_SEL_EN
   logic [1:0]           wave_r [NV];
   logic [1:0]           wave_d1_r;
   logic signed [15:0]   synth_s;
   logic signed [15:0]   synth_d1_r;
`endif

   // Register file: writes land the cycle after wr_en, in any controller state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NV; k++) begin
            fcw_r[k] <= '0;
            pha_r[k] <= '0;
            env_r[k] <= 16'sh0000;
`ifdef POLY_DDFS_WAVE_SEL_EN
            wave_r[k] <= WAVE_SINE;
`endif
         end
      end else if (wr_en && (int'(wr_voice) < NV)) begin
         case (wr_sel)
            SEL_FCW: fcw_r[wr_voice] <= wr_data;
            SEL_PHA: pha_r[wr_voice] <= wr_data;
            SEL_ENV: env_r[wr_voice] <= wr_data[15:0];
`ifdef POLY_DDFS_WAVE_SEL_EN
            SEL_WAVE: wave_r[wr_voice] <= wr_data[1:0];
`else
            SEL_WAVE: ;
`endif
            default: ;
         endcase
      end
   end

   // Phase accumulators: a voice advances only in the cycle it is issued.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NV; k++) begin
            phase_r[k] <= '0;
         end
      end else if (issue_s) begin
         phase_r[voice_r] <= phase_r[voice_r] + fcw_r[voice_r];
      end
   end

   // Controller next state; busy_r gates acceptance so a tick landing on the
   // pcm_valid cycle is treated as an overrun.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      finish_s     = 1'b0;
      issue_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (tick && !busy) begin
               next_state_s = ST_SWEEP;
               accept_s     = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_SWEEP: begin
            issue_s = 1'b1;
            if (voice_r == LAST_VOICE) begin
               next_state_s = ST_DRAIN;
            end else begin
               next_state_s = ST_SWEEP;
            end
         end
         ST_DRAIN: begin
            if (drain_r == DRAIN_LAST) begin
               next_state_s = ST_IDLE;
               finish_s     = 1'b1;
            end else begin
               next_state_s = ST_DRAIN;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Controller state, voice index and drain counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         voice_r <= '0;
         drain_r <= 2'd0;
      end else begin
         state_r <= next_state_s;
         if (accept_s) begin
            voice_r <= '0;
         end else if (issue_s) begin
            voice_r <= (voice_r == LAST_VOICE) ? '0 : voice_r + VW'(1);
         end
         if (state_r == ST_DRAIN) begin
            drain_r <= drain_r + 2'd1;
         end else begin
            drain_r <= 2'd0;
         end
      end
   end

   // Address of the voice being issued.
   always_comb begin
      sum_s      = phase_r[voice_r] + pha_r[voice_r];
      rom_addr_s = sum_s[PW-1:PW-8];
   end

   music_rom #(
      .FILE_NAME (FILE_NAME)
   ) u_rom (
      .clk  (clk),
      .addr (rom_addr_s),
      .data (rom_data_s)
   );

`ifdef POLY_DDFS_WAVE_SEL_EN
   // Non-ROM waveforms are derived from the same phase sum and delayed to match the ROM.
   always_comb begin
      case (wave_r[voice_r])
         WAVE_SQUARE: synth_s = sum_s[PW-1] ? SQUARE_NEG : SQUARE_POS;
         WAVE_SAW:    synth_s = sum_s[PW-1:PW-16];
         default:     synth_s = 16'sh0000;
      endcase
   end

   // Amplitude source after the ROM latency.
   always_comb begin
      case (wave_d1_r)
         WAVE_SINE:   amp_s = rom_data_s;
         WAVE_SQUARE: amp_s = synth_d1_r;
         WAVE_SAW:    amp_s = synth_d1_r;
         default:     amp_s = 16'sh0000;
      endcase
   end
`else
   // All voices read the sine ROM.
   always_comb begin
      amp_s = rom_data_s;
   end
`endif

   // Stage 1 alignment: envelope (and waveform) travel beside the ROM read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issue_d1_r <= 1'b0;
         env_d1_r   <= 16'sh0000;
`ifdef POLY_DDFS_WAVE_SEL_EN
         wave_d1_r  <= WAVE_SINE;
         synth_d1_r <= 16'sh0000;
`endif
      end else begin
         issue_d1_r <= issue_s;
         env_d1_r   <= env_r[voice_r];
`ifdef POLY_DDFS_WAVE_SEL_EN
         wave_d1_r  <= wave_r[voice_r];
         synth_d1_r <= synth_s;
`endif
      end
   end

   // Full-width signed operands for the envelope multiply.
   always_comb begin
      env_ext_s = {{16{env_d1_r[15]}}, env_d1_r};
      amp_ext_s = {{16{amp_s[15]}}, amp_s};
      term_s    = q14_term(product_r);
   end

   // Stage 2: registered product.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issue_d2_r <= 1'b0;
         product_r  <= 32'sd0;
      end else begin
         issue_d2_r <= issue_d1_r;
         product_r  <= env_ext_s * amp_ext_s;
      end
   end

   // Stage 3: accumulator, cleared when a sweep is accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_r <= '0;
      end else if (accept_s) begin
         acc_r <= '0;
      end else if (issue_d2_r) begin
         acc_r <= acc_r + {{(AW-16){term_s[15]}}, term_s};
      end
   end

   // Clamp the wide sum into the 16-bit output range.
   always_comb begin
      if (acc_r > ACC_MAX) begin
         sat_s = SAT_MAX;
      end else if (acc_r < ACC_MIN) begin
         sat_s = SAT_MIN;
      end else begin
         sat_s = acc_r[15:0];
      end
   end

   // Output sample, strobe, busy and sticky overrun.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pcm_out   <= 16'h0000;
         pcm_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (finish_s) begin
            pcm_out   <= sat_s;
            pcm_valid <= 1'b1;
         end else begin
            pcm_valid <= 1'b0;
         end
         // busy stays up through the pcm_valid cycle, then drops.
         if (accept_s) begin
            busy <= 1'b1;
         end else if (pcm_valid) begin
            busy <= 1'b0;
         end
         if (tick && busy) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_poly_ddfs.sv
// tb_poly_ddfs -- self-checking bench for poly_ddfs (NV=4, PW=30).
// A behavioural model tracks each voice's fcw/pha/env/phase and computes the
// expected mix per tick from the arithmetic definition of the output.
module tb_poly_ddfs;

   localparam int NV = 4;
   localparam int PW = 30;
   localparam int unsigned MASK = 32'h3FFF_FFFF;

   logic          clk      = 1'b0;
   logic          reset_n  = 1'b1;
   logic          wr_en    = 1'b0;
   logic [1:0]    wr_voice = 2'd0;
   logic [1:0]    wr_sel   = 2'd0;
   logic [PW-1:0] wr_data  = '0;
   logic          tick     = 1'b0;
   logic [15:0]   pcm_out;
   logic          pcm_valid;
   logic          busy;
   logic          overrun;

   int checks = 0;
   int errors = 0;

   int unsigned m_fcw [NV];
   int unsigned m_pha [NV];
   int unsigned m_ph  [NV];
   int          m_env [NV];

   poly_ddfs #(.NV(NV), .PW(PW), .FILE_NAME("")) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en     (wr_en),
      .wr_voice  (wr_voice),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .tick      (tick),
      .pcm_out   (pcm_out),
      .pcm_valid (pcm_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Table definition: half-period parabola peaking at +/-32767.
   function automatic int rom_amp(input int a);
      if (a < 128) return (a * (128 - a) * 32767) / 4096;
      else         return -(((a - 128) * (256 - a) * 32767) / 4096);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NV; k++) begin
         m_fcw[k] = 0; m_pha[k] = 0; m_ph[k] = 0; m_env[k] = 0;
      end
   endtask

   task automatic model_write(input int v, input int s, input int unsigned d);
      logic signed [15:0] e;
      e = d[15:0];
      case (s)
         0: m_fcw[v] = d & MASK;
         1: m_pha[v] = d & MASK;
         2: m_env[v] = int'(e);
         default: ;
      endcase
   endtask

   // One sweep: sum of env*amp/2^14 (wrapped to 16 bits), then clamp; phases advance.
   task automatic model_sweep(output int expv);
      int acc;
      acc = 0;
      for (int k = 0; k < NV; k++) begin
         int unsigned s;
         int prod;
         int t;
         logic signed [15:0] t16;
         s    = (m_ph[k] + m_pha[k]) & MASK;
         prod = m_env[k] * rom_amp(int'(s >> (PW - 8)));
         t    = prod >>> 14;
         t16  = t[15:0];
         acc += int'(t16);
         m_ph[k] = (m_ph[k] + m_fcw[k]) & MASK;
      end
      if (acc > 32767)       expv = 32767;
      else if (acc < -32768) expv = -32768;
      else                   expv = acc;
   endtask

   task automatic do_write(input int v, input int s, input int unsigned d);
      wr_en = 1'b1; wr_voice = v[1:0]; wr_sel = s[1:0]; wr_data = d[PW-1:0];
      @(posedge clk); #1;
      wr_en = 1'b0;
      model_write(v, s, d);
   endtask

   // Tick, optionally writing a register in the cycle voice 0 is issued.
   task automatic do_tick(input string tag, input bit mw, input int mv, input int ms,
                          input int unsigned md, output int got);
      int expv;
      int n;
      int bcnt;
      if (mw && mv >= 1) model_write(mv, ms, md);
      model_sweep(expv);
      if (mw && mv == 0) model_write(mv, ms, md);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      if (mw) begin
         wr_en = 1'b1; wr_voice = mv[1:0]; wr_sel = ms[1:0]; wr_data = md[PW-1:0];
      end
      n = 1; bcnt = 0;
      while (n <= 40) begin
         if (busy) bcnt++;
         if (pcm_valid) break;
         @(posedge clk); #1;
         wr_en = 1'b0;
         n++;
      end
      wr_en = 1'b0;
      chk({tag, "_latency"}, n, NV + 4);
      chk({tag, "_busy_cycles"}, bcnt, NV + 4);
      chk({tag, "_pcm"}, int'($signed(pcm_out)), expv);
      got = int'($signed(pcm_out));
      @(posedge clk); #1;
      chk({tag, "_busy_after"}, int'(busy), 0);
      chk({tag, "_hold"}, int'($signed(pcm_out)), expv);
   endtask

   initial begin
      int got;
      int vcount;
      int expv;
      model_reset();

      // Reset state
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pcm", int'(pcm_out), 0);
      chk("rst_valid", int'(pcm_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Silent mix
      do_tick("silent", 1'b0, 0, 0, 0, got);
      chk("silent_zero", got, 0);

      // One full sine period on voice 0
      do_write(0, 0, 32'h0040_0000);
      do_write(0, 2, 32'h0000_4000);
      for (int i = 0; i < 256; i++) begin
         do_tick("sine", 1'b0, 0, 0, 0, got);
         if (i == 64)  chk("sine_peak", got, 32767);
         if (i == 192) chk("sine_trough", got, -32767);
      end

      // Randomized voices with random mid-sweep writes
      for (int i = 0; i < 24; i++) begin
         for (int k = 0; k < NV; k++) begin
            do_write(k, 0, $urandom & MASK);
            do_write(k, 1, $urandom & MASK);
            do_write(k, 2, $urandom_range(0, 16'hFFFF));
         end
         do_tick("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)),
                 int'($urandom_range(0, 2)), $urandom & MASK, got);
      end

      // Directed mid-sweep writes: voice 3 takes effect now, voice 0 next sweep
      for (int k = 0; k < NV; k++) begin
         do_write(k, 0, 0);
         do_write(k, 1, ((32'd64 << 22) - m_ph[k]) & MASK);
         do_write(k, 2, 0);
      end
      do_tick("mid_v3", 1'b1, 3, 2, 32'h0000_4000, got);
      chk("mid_v3_now", got, 32767);
      do_tick("mid_v0", 1'b1, 0, 2, 32'h0000_2000, got);
      chk("mid_v0_later", got, 32767);
      do_tick("mid_v0b", 1'b0, 0, 0, 0, got);
      chk("mid_v0_applied", got, 32767 + 16383 > 32767 ? 32767 : 0);

      // Saturation both ways
      for (int k = 0; k < NV; k++) begin
         do_write(k, 1, ((32'd64 << 22) - m_ph[k]) & MASK);
         do_write(k, 2, 32'h0000_4000);
      end
      do_tick("sat_pos", 1'b0, 0, 0, 0, got);
      chk("sat_pos_val", got, 32767);
      for (int k = 0; k < NV; k++) begin
         do_write(k, 1, ((32'd192 << 22) - m_ph[k]) & MASK);
      end
      do_tick("sat_neg", 1'b0, 0, 0, 0, got);
      chk("sat_neg_val", got, -32768);

      // Tick while busy
      model_sweep(expv);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      @(posedge clk); #1;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      vcount = 0;
      repeat (20) begin
         if (pcm_valid) vcount++;
         @(posedge clk); #1;
      end
      chk("ovr_valid_count", vcount, 1);
      chk("ovr_flag", int'(overrun), 1);
      chk("ovr_pcm", int'($signed(pcm_out)), expv);

      // Reset three cycles into a sweep
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mrst_pcm", int'(pcm_out), 0);
      chk("mrst_valid", int'(pcm_valid), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_overrun", int'(overrun), 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      vcount = 0;
      repeat (15) begin
         if (pcm_valid) vcount++;
         @(posedge clk); #1;
      end
      chk("mrst_no_valid", vcount, 0);
      do_write(0, 1, 32'd64 << 22);
      do_write(0, 2, 32'h0000_4000);
      do_tick("post_rst", 1'b0, 0, 0, 0, got);
      chk("post_rst_val", got, 32767);

`ifdef POLY_DDFS_WAVE_SEL_EN
      // Square and silence on voice 0
      do_write(0, 0, 0);
      do_write(0, 1, ((32'd1 << 29) - m_ph[0]) & MASK);
      do_write(0, 2, 32'h0000_4000);
      do_write(0, 3, 1);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (NV + 4) @(posedge clk);
      #1;
      chk("square_neg", int'($signed(pcm_out)), -32767);
      do_write(0, 3, 3);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (NV + 4) @(posedge clk);
      #1;
      chk("silence", int'($signed(pcm_out)), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
